// File: rtl/fp_div_unit_if.sv
// Start/done handshake and result bus between the execute stage and the FP divider.
interface fp_div_unit_if;
    logic        start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        busy;
    logic        done;
    logic [31:0] out_quot;
    logic        div_zero;
    logic        invalid;

    modport master (
        output start, div_a, div_b,
        input  busy, done, out_quot, div_zero, invalid
    );

    modport slave (
        input  start, div_a, div_b,
        output busy, done, out_quot, div_zero, invalid
    );
endinterface

// File: rtl/fp_div_unit.sv
// IEEE-754 single-precision divider, restoring division one quotient bit per cycle,
// round-to-nearest-even with denormal, zero, inf and NaN handling.
//
// state    | meaning
// IDLE     | waiting for start, result and flags held
// UNPACK   | split operands into sign, unbiased exponent, 24-bit mantissa
// SPECIAL  | NaN/inf/zero operands resolved directly
// NORM_A   | left-normalise denormal dividend
// NORM_B   | left-normalise denormal divisor
// DIV_INIT | exponent difference, load remainder
// DIVIDE   | 27 restoring-division steps
// NORM_1   | single left shift when quotient < 1
// NORM_2   | right shift into denormal range
// ROUND    | round-to-nearest-even
// PACK     | assemble result, pulse done
module fp_div_unit #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input logic          clk,
    input logic          rst,
    fp_div_unit_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_DIV_INIT,
        S_DIVIDE, S_NORM_1, S_NORM_2, S_ROUND, S_PACK
    } state_t;

    localparam logic signed [9:0] E_MIN = -10'sd126;
    localparam logic signed [9:0] E_MAX = 10'sd127;

    state_t             state;
    logic        [31:0] op_a, op_b;
    logic               z_s;
    logic signed [9:0]  a_e, b_e, z_e;
    logic        [23:0] a_m, b_m, z_m;
    logic        [24:0] rem;
    logic        [26:0] quo;
    logic        [4:0]  div_cnt;
    logic               guard, round_b, sticky;
    logic        [31:0] spec_q;
    logic               spec_dz, spec_inv, spec_hit;
    logic               busy_r, done_r, div_zero_r, invalid_r;
    logic        [31:0] out_quot_r;

    logic [7:0]  a_exp_f, b_exp_f;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
    logic [25:0] rem_diff;
    logic        div_ge;
    logic [24:0] rem_keep, rem_nxt;
    logic [26:0] quo_nxt;
    logic signed [9:0] z_e_n1, z_e_inc;
    logic [7:0]  pack_exp;

    assign a_exp_f    = op_a[30:23];
    assign b_exp_f    = op_b[30:23];
    assign a_nan      = (a_exp_f == 8'hFF) && (op_a[22:0] != 23'd0);
    assign b_nan      = (b_exp_f == 8'hFF) && (op_b[22:0] != 23'd0);
    assign a_inf      = (a_exp_f == 8'hFF) && (op_a[22:0] == 23'd0);
    assign b_inf      = (b_exp_f == 8'hFF) && (op_b[22:0] == 23'd0);
    assign a_zero     = (a_exp_f == 8'h00) && (op_a[22:0] == 23'd0);
    assign b_zero     = (b_exp_f == 8'h00) && (op_b[22:0] == 23'd0);
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // remainder stays below 2*b_m, so 25 bits hold it after the shift
    assign rem_diff = {1'b0, rem} - {2'b00, b_m};
    assign div_ge   = ~rem_diff[25];
    assign rem_keep = div_ge ? rem_diff[24:0] : rem;
    assign rem_nxt  = rem_keep << 1;
    assign quo_nxt  = {quo[25:0], div_ge};

    assign z_e_n1   = z_m[23] ? z_e : (z_e - 10'sd1);
    assign z_e_inc  = z_e + 10'sd1;
    assign pack_exp = 8'(z_e + 10'sd127);

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.out_quot = out_quot_r;
    assign bus.div_zero = div_zero_r;
    assign bus.invalid  = invalid_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            out_quot_r <= 32'd0;
            div_zero_r <= 1'b0;
            invalid_r  <= 1'b0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            z_s        <= 1'b0;
            a_e        <= '0;
            b_e        <= '0;
            z_e        <= '0;
            a_m        <= '0;
            b_m        <= '0;
            z_m        <= '0;
            rem        <= '0;
            quo        <= '0;
            div_cnt    <= '0;
            guard      <= 1'b0;
            round_b    <= 1'b0;
            sticky     <= 1'b0;
            spec_q     <= 32'd0;
            spec_dz    <= 1'b0;
            spec_inv   <= 1'b0;
            spec_hit   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.div_a;
                        op_b   <= bus.div_b;
                        busy_r <= 1'b1;
                        state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    z_s   <= op_a[31] ^ op_b[31];
                    a_e   <= (a_exp_f == 8'd0) ? E_MIN : ($signed({2'b00, a_exp_f}) - 10'sd127);
                    b_e   <= (b_exp_f == 8'd0) ? E_MIN : ($signed({2'b00, b_exp_f}) - 10'sd127);
                    a_m   <= {a_exp_f != 8'd0, op_a[22:0]};
                    b_m   <= {b_exp_f != 8'd0, op_b[22:0]};
                    state <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    spec_hit <= is_special;
                    spec_dz  <= 1'b0;
                    spec_inv <= 1'b0;
                    spec_q   <= {z_s, 31'd0};
                    if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
                        spec_q   <= QNAN;
                        spec_inv <= 1'b1;
                    end else if (a_inf) begin
                        spec_q <= {z_s, 8'hFF, 23'd0};
                    end else if (b_inf) begin
                        spec_q <= {z_s, 31'd0};
                    end else if (b_zero) begin
                        spec_q  <= {z_s, 8'hFF, 23'd0};
                        spec_dz <= 1'b1;
                    end
                    state <= is_special ? S_PACK : S_NORM_A;
                end
                S_NORM_A: begin
                    if (a_m[23]) begin
                        state <= S_NORM_B;
                    end else begin
                        a_m <= a_m << 1;
                        a_e <= a_e - 10'sd1;
                    end
                end
                S_NORM_B: begin
                    if (b_m[23]) begin
                        state <= S_DIV_INIT;
                    end else begin
                        b_m <= b_m << 1;
                        b_e <= b_e - 10'sd1;
                    end
                end
                S_DIV_INIT: begin
                    z_e     <= a_e - b_e;
                    rem     <= {1'b0, a_m};
                    quo     <= '0;
                    div_cnt <= 5'd26;
                    state   <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    quo     <= quo_nxt;
                    rem     <= rem_nxt;
                    div_cnt <= div_cnt - 5'd1;
                    if (div_cnt == 5'd0) begin
                        z_m     <= quo_nxt[26:3];
                        guard   <= quo_nxt[2];
                        round_b <= quo_nxt[1];
                        sticky  <= quo_nxt[0] | (rem_nxt != 25'd0);
                        state   <= S_NORM_1;
                    end
                end
                S_NORM_1: begin
                    if (!z_m[23]) begin
                        z_m     <= {z_m[22:0], guard};
                        guard   <= round_b;
                        round_b <= 1'b0;
                        z_e     <= z_e_n1;
                    end
                    state <= (z_e_n1 < E_MIN) ? S_NORM_2 : S_ROUND;
                end
                S_NORM_2: begin
                    // once every bit has drained into sticky, further shifts change nothing
                    if ((z_m == 24'd0) && !guard && !round_b) begin
                        z_e   <= E_MIN;
                        state <= S_ROUND;
                    end else begin
                        z_m     <= z_m >> 1;
                        guard   <= z_m[0];
                        round_b <= guard;
                        sticky  <= sticky | round_b;
                        z_e     <= z_e_inc;
                        if (z_e_inc >= E_MIN) state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (guard & (round_b | sticky | z_m[0])) begin
                        if (z_m == 24'hFF_FFFF) begin
                            z_m <= 24'h80_0000;
                            z_e <= z_e_inc;
                        end else begin
                            z_m <= z_m + 24'd1;
                        end
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                    if (spec_hit) begin
                        out_quot_r <= spec_q;
                        div_zero_r <= spec_dz;
                        invalid_r  <= spec_inv;
                    end else begin
                        div_zero_r <= 1'b0;
                        invalid_r  <= 1'b0;
                        if (z_e > E_MAX)
                            out_quot_r <= {z_s, 8'hFF, 23'd0};
                        else if ((z_e == E_MIN) && !z_m[23])
                            out_quot_r <= {z_s, 8'd0, z_m[22:0]};
                        else
                            out_quot_r <= {z_s, pack_exp, z_m[22:0]};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_unit.sv
// Bench for fp_div_unit: directed corner cases, handshake/reset scenarios and
// random operands checked against an exact big-integer division model.
module tb_fp_div_unit;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   overlap;

    fp_div_unit_if bus ();

    fp_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int N_DIR = 14;
    logic [31:0] dir_a   [0:N_DIR-1] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                                         32'h7F800001, 32'h00800000, 32'h7F7FFFFF, 32'h00400000,
                                         32'h7F800000, 32'hC0000000, 32'hFF800000, 32'hBF800000,
                                         32'h00000001, 32'h00000000};
    logic [31:0] dir_b   [0:N_DIR-1] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                         32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000,
                                         32'hFF800000, 32'h7F800000, 32'h40000000, 32'h3F800000,
                                         32'h7F000000, 32'hC0000000};
    logic [31:0] dir_q   [0:N_DIR-1] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, QNAN,
                                         QNAN,         32'h00400000, 32'h7F800000, 32'h00400000,
                                         QNAN,         32'h80000000, 32'hFF800000, 32'hBF800000,
                                         32'h00000000, 32'h80000000};
    logic        dir_dz  [0:N_DIR-1] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic        dir_inv [0:N_DIR-1] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int          dir_lat [0:N_DIR-1] = '{35, 35, 3, 3, 3, 36, 35, 37, 3, 3, 3, 35, -1, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Exact model: quotient of the two significands as wide integers, then one RNE rounding.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic dz, output logic inv);
        logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
        logic [7:0]   xa, xb;
        logic [127:0] sa, sb, num, quo, rmd, mant, lowmask;
        int           ea, eb, e, p, big_e, lsb, sh;
        s  = a[31] ^ b[31];
        xa = a[30:23];
        xb = b[30:23];
        dz = 1'b0;
        inv = 1'b0;
        a_nan  = (xa == 8'hFF) && (a[22:0] != 0);
        b_nan  = (xb == 8'hFF) && (b[22:0] != 0);
        a_inf  = (xa == 8'hFF) && (a[22:0] == 0);
        b_inf  = (xb == 8'hFF) && (b[22:0] == 0);
        a_zero = (xa == 8'h00) && (a[22:0] == 0);
        b_zero = (xb == 8'h00) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            q = QNAN; inv = 1'b1; return;
        end
        if (a_inf)  begin q = {s, 8'hFF, 23'd0}; return; end
        if (b_inf)  begin q = {s, 31'd0}; return; end
        if (b_zero) begin q = {s, 8'hFF, 23'd0}; dz = 1'b1; return; end
        if (a_zero) begin q = {s, 31'd0}; return; end
        sa  = (xa == 0) ? 128'(a[22:0]) : 128'({1'b1, a[22:0]});
        sb  = (xb == 0) ? 128'(b[22:0]) : 128'({1'b1, b[22:0]});
        ea  = (xa == 0) ? -149 : int'(xa) - 150;
        eb  = (xb == 0) ? -149 : int'(xb) - 150;
        num = sa << 62;
        quo = num / sb;
        rmd = num % sb;
        e   = ea - eb - 62;
        p   = 0;
        for (int i = 0; i < 128; i++) if (quo[i]) p = i;
        big_e = p + e;
        if (big_e > 127) begin q = {s, 8'hFF, 23'd0}; return; end
        lsb = (big_e >= -126) ? big_e - 23 : -149;
        sh  = lsb - e;
        if (sh > 120) begin
            mant = 0; g = 1'b0; st = 1'b1;
        end else begin
            mant    = quo >> sh;
            g       = quo[sh-1];
            lowmask = (128'd1 << (sh - 1)) - 128'd1;
            st      = ((quo & lowmask) != 0) || (rmd != 0);
        end
        if (g && (st || mant[0])) mant = mant + 128'd1;
        if (lsb == -149) begin
            q = {s, mant[30:0]};
        end else begin
            if (mant[24]) begin mant = mant >> 1; big_e++; end
            if (big_e > 127) q = {s, 8'hFF, 23'd0};
            else             q = {s, 8'(big_e + 127), mant[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] f;
        int cls;
        f   = $urandom;
        cls = $urandom_range(0, 15);
        case (cls)
            0:       f[30:23] = 8'h00;
            1:       f[30:0]  = 31'd0;
            2:       f[30:0]  = {8'hFF, 23'd0};
            3:       begin f[30:23] = 8'hFF; f[0] = 1'b1; end
            15:      f[30:23] = 8'($urandom_range(1, 254));
            default: f[30:23] = 8'($urandom_range(90, 164));
        endcase
        return f;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic dz, output logic inv, output int lat);
        logic got;
        @(negedge clk);
        bus.div_a = a;
        bus.div_b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 120) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) got = 1'b1;
        end
        if (!got) lat = 999;
        q   = bus.out_quot;
        dz  = bus.div_zero;
        inv = bus.invalid;
    endtask

    initial begin
        logic [31:0] q, eq;
        logic        dz, inv, edz, einv, stable;
        int          lat, pulses;

        n_checks  = 0;
        n_errors  = 0;
        overlap   = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.div_a = 32'd0;
        bus.div_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_quot", bus.out_quot, 32'd0);
        check("reset_flags", {30'd0, bus.div_zero, bus.invalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed corners; consecutive ops also start in the previous done cycle
        for (int i = 0; i < N_DIR; i++) begin
            run_op(dir_a[i], dir_b[i], q, dz, inv, lat);
            check($sformatf("dir%0d_quot", i), q, dir_q[i]);
            check($sformatf("dir%0d_flags", i), {30'd0, dz, inv}, {30'd0, dir_dz[i], dir_inv[i]});
            if (dir_lat[i] >= 0) check($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir_lat[i]));
        end

        // start held for three cycles: one op, one done pulse, result held afterwards
        @(negedge clk);
        bus.div_a = 32'h40C00000;
        bus.div_b = 32'h40000000;
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        stable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
            if (pulses > 0 && bus.out_quot !== 32'h40400000) stable = 1'b0;
        end
        check("held_start_pulses", 32'(pulses), 32'd1);
        check("held_start_quot", bus.out_quot, 32'h40400000);
        check("held_start_stable", 32'(stable), 32'd1);
        check("held_start_busy", 32'(bus.busy), 32'd0);

        // reset ten cycles into an op aborts it without a done
        @(negedge clk);
        bus.div_a = 32'h3F800000;
        bus.div_b = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_quot", bus.out_quot, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_op(32'h3F800000, 32'h40400000, q, dz, inv, lat);
        check("after_abort_quot", q, 32'h3EAAAAAB);
        check("after_abort_latency", 32'(lat), 32'd35);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra, rb;
            ra = rand_fp();
            rb = rand_fp();
            ref_div(ra, rb, eq, edz, einv);
            run_op(ra, rb, q, dz, inv, lat);
            check($sformatf("rnd%0d_quot %h/%h", i, ra, rb), q, eq);
            check($sformatf("rnd%0d_flags", i), {30'd0, dz, inv}, {30'd0, edz, einv});
            check($sformatf("rnd%0d_latency_le_100 lat=%0d", i, lat), 32'(lat <= 100), 32'd1);
        end

        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
